// File: rtl/alu64_pkg.sv
// alu64_pkg: opcodes, flag indices and response entry layout shared by the ALU responder.
// The response entry carries {V,C,N,Z} only when ALU64_FLAGS_EN is defined.
package alu64_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
`ifdef ALU64_FLAGS_EN
  typedef struct packed {
    logic       err;
    logic [3:0] flags;
  } rsp_meta_t;
`else
  typedef struct packed {
    logic err;
  } rsp_meta_t;
`endif
  localparam int META_W = $bits(rsp_meta_t);
endpackage

// File: rtl/alu64_if.sv
// alu64_if: request/response valid-ready channels between issuing master and ALU responder.
// rsp_flags exists only when ALU64_FLAGS_EN is defined.
interface alu64_if #(parameter int WIDTH = 64);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
`ifdef ALU64_FLAGS_EN
  logic [3:0]       rsp_flags;
`endif
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
`ifdef ALU64_FLAGS_EN
    , input rsp_flags
`endif
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
`ifdef ALU64_FLAGS_EN
    , output rsp_flags
`endif
  );
endinterface

// File: rtl/alu64_rsp_fifo.sv
// alu64_rsp_fifo: DEPTH-entry synchronous FIFO (power-of-2 depth) with sync active-low reset.
module alu64_rsp_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  assign o_dout  = r_mem[r_rd];
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/alu64_responder.sv
// alu64_responder: computes AND/OR/XOR/ADD/SUB/NOT in the acceptance cycle and queues results in order.
// Optional ALU64_FLAGS_EN adds {V,C,N,Z} flags per response.
module alu64_responder
  import alu64_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input logic   clk,
  input logic   rst_n,
  alu64_if.slave bus
);
  localparam int EW = WIDTH + META_W;
  logic             w_sub;
  logic             w_err;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  rsp_meta_t        w_meta;
  logic [EW-1:0]    w_head;
  logic [WIDTH-1:0] w_head_res;
  rsp_meta_t        w_head_meta;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  // SUB reuses the adder as A + ~B + 1 so carry-out means "no borrow"
  always_comb begin
    w_sub = bus.req_op == OP_SUB;
    w_b   = w_sub ? ~bus.req_b : bus.req_b;
    w_sum = {1'b0, bus.req_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
    w_err = bus.req_op > OP_NOT;
    w_res = bus.req_op == OP_AND ? bus.req_a & bus.req_b :
            bus.req_op == OP_OR  ? bus.req_a | bus.req_b :
            bus.req_op == OP_XOR ? bus.req_a ^ bus.req_b :
            (bus.req_op == OP_ADD || w_sub) ? w_sum[WIDTH-1:0] :
            bus.req_op == OP_NOT ? ~bus.req_a : '0;
    w_meta     = '0;
    w_meta.err = w_err;
`ifdef ALU64_FLAGS_EN
    w_meta.flags[FLAG_Z] = !w_err && w_res == '0;
    w_meta.flags[FLAG_N] = w_res[WIDTH-1];
    w_meta.flags[FLAG_C] = (bus.req_op == OP_ADD || w_sub) && w_sum[WIDTH];
    w_meta.flags[FLAG_V] = (bus.req_op == OP_ADD || w_sub) &&
                           bus.req_a[WIDTH-1] == w_b[WIDTH-1] &&
                           w_sum[WIDTH-1] != bus.req_a[WIDTH-1];
`endif
  end
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign bus.req_ready = rst_n && (!w_full || w_pop);
  assign w_push        = bus.req_valid && bus.req_ready;
  alu64_rsp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({w_res, w_meta}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign {w_head_res, w_head_meta} = w_head;
  assign bus.rsp_valid  = !w_empty;
  assign bus.rsp_result = w_empty ? '0 : w_head_res;
  assign bus.rsp_err    = !w_empty && w_head_meta.err;
`ifdef ALU64_FLAGS_EN
  assign bus.rsp_flags  = w_empty ? '0 : w_head_meta.flags;
`endif
endmodule

// File: tb/tb_alu64_responder.sv
// tb_alu64_responder: directed vectors with hand-computed results for alu64_responder.
// Flag checks are active when ALU64_FLAGS_EN is defined.
module tb_alu64_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  alu64_if #(.WIDTH(64)) bus ();
  alu64_responder #(.WIDTH(64), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask
  task automatic check_rsp(input string tag, input logic [63:0] res, input logic err,
                           input logic [3:0] flags);
    check({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_res"}, bus.rsp_result, res);
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
`ifdef ALU64_FLAGS_EN
    check({tag, "_flags"}, 64'(bus.rsp_flags), 64'(flags));
`else
    if (flags === 4'hx) $display("unexpected x flags in %s", tag);
`endif
  endtask
  // one request with rsp_ready=1: no same-cycle response, one-cycle latency, then drained
  task automatic single(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] res, input logic err,
                        input logic [3:0] flags);
    bus.rsp_ready = 1'b1;
    drive(op, a, b);
    @(negedge clk);
    check({tag, "_nocomb"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_rsp(tag, res, err, flags);
    step();
    @(negedge clk);
    check({tag, "_drained"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_zero"}, bus.rsp_result, 64'd0);
    step();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(3'b011, 64'd7, 64'd9);
    step();
    step();
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    step();
    single("and", 3'b000, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
           64'h0F0F_0000_0F0F_0000, 1'b0, 4'b0000);
    single("add_wrap", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 4'b0101);
    single("sub_ovf", 3'b100, 64'h8000_0000_0000_0000, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'b1100);
    single("illegal", 3'b110, 64'h1234, 64'h1234, 64'd0, 1'b1, 4'b0000);
    single("illegal7", 3'b111, 64'h5, 64'h3, 64'd0, 1'b1, 4'b0000);
    single("sub_ok", 3'b100, 64'd5, 64'd3, 64'd2, 1'b0, 4'b0100);
    // backpressure: two fill the buffer, third waits and enters on the first pop
    bus.rsp_ready = 1'b0;
    drive(3'b010, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);
    check("bp_rdy0", 64'(bus.req_ready), 64'd1);
    step();
    drive(3'b001, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);
    check("bp_rdy1", 64'(bus.req_ready), 64'd1);
    step();
    drive(3'b101, 64'h00FF_00FF_00FF_00FF, 64'd0);
    @(negedge clk);
    check("bp_full", 64'(bus.req_ready), 64'd0);
    check_rsp("bp_head", 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 4'b0000);
    step();
    @(negedge clk);
    check("bp_full2", 64'(bus.req_ready), 64'd0);
    check_rsp("bp_stable", 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 4'b0000);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pushpop", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_rsp("bp_or", 64'h0FFF_0FFF_0FFF_0FFF, 1'b0, 4'b0000);
    step();
    @(negedge clk);
    check_rsp("bp_not", 64'hFF00_FF00_FF00_FF00, 1'b0, 4'b0010);
    step();
    @(negedge clk);
    check("bp_empty", 64'(bus.rsp_valid), 64'd0);
    step();
    // reset with two entries buffered
    bus.rsp_ready = 1'b0;
    drive(3'b011, 64'd1, 64'd2);
    step();
    drive(3'b011, 64'd3, 64'd4);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_two", 64'(bus.rsp_valid), 64'd1);
    step();
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_res", bus.rsp_result, 64'd0);
    step();
    single("post_mid", 3'b011, 64'd10, 64'd20, 64'd30, 1'b0, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
